// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP RX video deframer.
package udp_rx_pkg;

  typedef enum logic [1:0] {
    StHunt = 2'd0,
    StChan = 2'd1,
    StRec  = 2'd2
  } rx_state_e;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrBadCh   = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  localparam logic [31:0] FrameHeadDefault = 32'hF3ED7A93;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/udp_rx_vid_deframer_if.sv
// Byte stream in from udp_top and VTC-style video stream out of the deframer.
interface udp_rx_vid_deframer_if #(
  parameter int unsigned PIX_BYTES = 2,
  parameter int unsigned N_CH      = 1
);
  localparam int unsigned CH_W = udp_rx_pkg::cnt_width(N_CH);

  logic                   app_rx_data_valid;
  logic [7:0]             app_rx_data;
  logic                   vid_clk;
  logic                   vid_vs;
  logic                   vid_de;
  logic [8*PIX_BYTES-1:0] vid_data;
  logic [CH_W-1:0]        vid_ch;
  logic                   vid_eol;
  logic                   vid_eof;
  logic [15:0]            frame_cnt;
  logic                   err_pulse;
  logic [1:0]             err_code;

  // Byte source / video sink side.
  modport master (
    output app_rx_data_valid, app_rx_data,
    input  vid_clk, vid_vs, vid_de, vid_data, vid_ch, vid_eol, vid_eof,
    input  frame_cnt, err_pulse, err_code
  );

  // Deframer side.
  modport slave (
    input  app_rx_data_valid, app_rx_data,
    output vid_clk, vid_vs, vid_de, vid_data, vid_ch, vid_eol, vid_eof,
    output frame_cnt, err_pulse, err_code
  );

endinterface

// File: rtl/udp_rx_pix_pack.sv
// Packs PIX_BYTES bytes MSB-first into one pixel; pixel appears one cycle after its last byte.
module udp_rx_pix_pack #(
  parameter int unsigned PIX_BYTES = 2
) (
  input  logic                   app_rx_clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [7:0]             in_byte,
  output logic [8*PIX_BYTES-1:0] pix,
  output logic                   pix_valid,
  output logic                   pix_done
);
  localparam int unsigned PW = 8 * PIX_BYTES;
  localparam int unsigned IW = udp_rx_pkg::cnt_width(PIX_BYTES);

  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] sr_q, sr_d;
  logic [PW-1:0] pix_q, pix_d;
  logic          pv_q, pv_d;
  logic [PW-1:0] word_next;

  assign word_next = (sr_q << 8) | PW'(in_byte);
  assign pix_done  = in_valid && !clear && (idx_q == IW'(PIX_BYTES - 1));

  always_comb begin
    idx_d = idx_q;
    sr_d  = sr_q;
    pix_d = '0;
    pv_d  = 1'b0;
    if (clear) begin
      idx_d = '0;
      sr_d  = '0;
    end else if (in_valid) begin
      if (pix_done) begin
        idx_d = '0;
        sr_d  = '0;
        pix_d = word_next;
        pv_d  = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
        sr_d  = word_next;
      end
    end
  end

  always_ff @(posedge app_rx_clk or negedge rstn) begin
    if (!rstn) begin
      idx_q <= '0;
      sr_q  <= '0;
      pix_q <= '0;
      pv_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      sr_q  <= sr_d;
      pix_q <= pix_d;
      pv_q  <= pv_d;
    end
  end

  assign pix       = pix_q;
  assign pix_valid = pv_q;

endmodule

// File: rtl/udp_rx_vid_deframer.sv
// UDP RX video deframer: header hunt, channel check, pixel packing, line/frame markers, timeout abort.
module udp_rx_vid_deframer
  import udp_rx_pkg::*;
#(
  parameter logic [31:0] FRAME_HEAD  = FrameHeadDefault,
  parameter int unsigned PIX_BYTES   = 2,
  parameter int unsigned N_CH        = 1,
  parameter int unsigned LINE_PIX    = 1024,
  parameter int unsigned FRAME_BYTES = 1572864,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input logic                   app_rx_clk,
  input logic                   rstn,
  udp_rx_vid_deframer_if.slave  bus
);
  localparam int unsigned PW   = 8 * PIX_BYTES;
  localparam int unsigned CH_W = cnt_width(N_CH);
  localparam int unsigned BC_W = cnt_width(FRAME_BYTES);
  localparam int unsigned PC_W = cnt_width(LINE_PIX);
  localparam int unsigned IC_W = cnt_width(TIMEOUT_CYC);

  rx_state_e       state_q, state_d;
  logic [31:0]     hdr_q, hdr_d, hdr_next;
  logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [PC_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [IC_W-1:0] idle_q, idle_d;
  logic            vs_q, vs_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            eol_q, eol_d;
  logic            eof_q, eof_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            err_pulse_q, err_pulse_d;
  logic [1:0]      err_code_q, err_code_d;

  logic            valid;
  logic            idle_hit;
  logic            rec_byte;
  logic            pack_clear;
  logic [PW-1:0]   pix;
  logic            pix_valid;
  logic            pix_done;

  assign valid      = bus.app_rx_data_valid;
  assign hdr_next   = {hdr_q[23:0], bus.app_rx_data};
  assign idle_hit   = (idle_q == IC_W'(TIMEOUT_CYC - 1));
  assign rec_byte   = valid && (state_q == StRec);
  // Packer is held clear outside REC so an aborted pixel never leaks into the next frame.
  assign pack_clear = (state_q != StRec);

  udp_rx_pix_pack #(
    .PIX_BYTES (PIX_BYTES)
  ) u_pix_pack (
    .app_rx_clk (app_rx_clk),
    .rstn       (rstn),
    .clear      (pack_clear),
    .in_valid   (rec_byte),
    .in_byte    (bus.app_rx_data),
    .pix        (pix),
    .pix_valid  (pix_valid),
    .pix_done   (pix_done)
  );

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    byte_cnt_d  = byte_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    idle_d      = idle_q;
    vs_d        = 1'b0;
    ch_d        = ch_q;
    eol_d       = 1'b0;
    eof_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;

    unique case (state_q)
      StHunt: begin
        byte_cnt_d = '0;
        pix_cnt_d  = '0;
        idle_d     = '0;
        if (valid) begin
          if (hdr_next == FRAME_HEAD) begin
            state_d = StChan;
            hdr_d   = '0;
          end else begin
            hdr_d = hdr_next;
          end
        end
      end
      StChan: begin
        if (valid) begin
          idle_d = '0;
          if (32'(bus.app_rx_data) < N_CH) begin
            state_d = StRec;
            vs_d    = 1'b1;
            ch_d    = bus.app_rx_data[CH_W-1:0];
          end else begin
            state_d     = StHunt;
            err_pulse_d = 1'b1;
            err_code_d  = ErrBadCh;
          end
        end else if (idle_hit) begin
          state_d     = StHunt;
          idle_d      = '0;
          err_pulse_d = 1'b1;
          err_code_d  = ErrTimeout;
        end else begin
          idle_d = idle_q + IC_W'(1);
        end
      end
      StRec: begin
        if (valid) begin
          idle_d     = '0;
          byte_cnt_d = byte_cnt_q + BC_W'(1);
          if (pix_done) begin
            eol_d     = (pix_cnt_q == PC_W'(LINE_PIX - 1));
            pix_cnt_d = eol_d ? '0 : pix_cnt_q + PC_W'(1);
          end
          if (byte_cnt_q == BC_W'(FRAME_BYTES - 1)) begin
            state_d     = StHunt;
            eof_d       = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end else if (idle_hit) begin
          state_d     = StHunt;
          idle_d      = '0;
          err_pulse_d = 1'b1;
          err_code_d  = ErrTimeout;
        end else begin
          idle_d = idle_q + IC_W'(1);
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge app_rx_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StHunt;
      hdr_q       <= '0;
      byte_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      idle_q      <= '0;
      vs_q        <= 1'b0;
      ch_q        <= '0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      frame_cnt_q <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ErrNone;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      byte_cnt_q  <= byte_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      idle_q      <= idle_d;
      vs_q        <= vs_d;
      ch_q        <= ch_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      frame_cnt_q <= frame_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.vid_clk   = app_rx_clk;
  assign bus.vid_vs    = vs_q;
  assign bus.vid_de    = pix_valid;
  assign bus.vid_data  = pix;
  assign bus.vid_ch    = ch_q;
  assign bus.vid_eol   = eol_q;
  assign bus.vid_eof   = eof_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_udp_rx_vid_deframer.sv
// Randomised bench for udp_rx_vid_deframer; observed events are compared with a byte-stream model.
module tb_udp_rx_vid_deframer;
  localparam int unsigned PIX_BYTES   = 2;
  localparam int unsigned N_CH        = 2;
  localparam int unsigned LINE_PIX    = 4;
  localparam int unsigned FRAME_BYTES = 16;
  localparam int unsigned TIMEOUT_CYC = 20;
  localparam logic [31:0] HEAD        = 32'hF3ED7A93;
  localparam int K_VS = 1, K_DE = 2, K_ERR = 3, K_BAD = 4;

  typedef logic [79:0] sig_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  udp_rx_vid_deframer_if #(.PIX_BYTES(PIX_BYTES), .N_CH(N_CH)) bus ();

  udp_rx_vid_deframer #(
    .FRAME_HEAD  (HEAD),
    .PIX_BYTES   (PIX_BYTES),
    .N_CH        (N_CH),
    .LINE_PIX    (LINE_PIX),
    .FRAME_BYTES (FRAME_BYTES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .app_rx_clk (clk),
    .rstn       (rstn),
    .bus        (bus)
  );

  always #4 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int idle_data_bad = 0;
  bit         log_v[$];
  logic [7:0] log_d[$];
  sig_t       obs[$];
  sig_t       exp_s[$];
  sig_t       obs_s[$];
  int m_frames, m_err, m_ch;

  function automatic sig_t mk(int idx, int kind, int data, bit eol, bit eof, int aux);
    return {idx[31:0], kind[3:0], data[31:0], eol, eof, 2'b00, aux[7:0]};
  endfunction

  // One clock of stimulus; outputs are sampled 1 time unit after the edge that consumed it.
  task automatic step(input bit v, input logic [7:0] d);
    int idx;
    @(negedge clk);
    bus.app_rx_data_valid = v;
    bus.app_rx_data       = v ? d : 8'h00;
    @(posedge clk);
    #1;
    log_v.push_back(v);
    log_d.push_back(d);
    idx = log_v.size() - 1;
    if (bus.vid_vs) obs.push_back(mk(idx, K_VS, 0, 1'b0, 1'b0, int'(bus.vid_ch)));
    if (bus.vid_de) obs.push_back(mk(idx, K_DE, int'(bus.vid_data), bus.vid_eol, bus.vid_eof, 0));
    if (bus.err_pulse) obs.push_back(mk(idx, K_ERR, 0, 1'b0, 1'b0, int'(bus.err_code)));
    if (!bus.vid_de && (bus.vid_eol || bus.vid_eof)) obs.push_back(mk(idx, K_BAD, 0, 1'b0, 1'b0, 0));
    if (!bus.vid_de && bus.vid_data != '0) idle_data_bad++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b, input int maxgap);
    idle((maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    step(1'b1, b);
  endtask

  task automatic send_head(input int maxgap);
    logic [31:0] h;
    h = HEAD;
    for (int k = 3; k >= 0; k--) send(h[8*k +: 8], maxgap);
  endtask

  task automatic send_frame(input logic [7:0] ch, input int maxgap);
    send_head(maxgap);
    send(ch, maxgap);
    for (int k = 0; k < int'(FRAME_BYTES); k++) send(8'($urandom), maxgap);
  endtask

  // Reference model: replays the logged byte stream from the rules of the frame format.
  function automatic void build(input int start);
    int mode = 0;
    logic [31:0] w = '0;
    int idle_n = 0, nbytes = 0, npix = 0, val;
    logic [7:0] pb[$];
    bit eol, eof;
    exp_s.delete();
    obs_s.delete();
    m_frames = 0;
    m_err    = 0;
    m_ch     = 0;
    for (int i = 0; i < log_v.size(); i++) begin
      if (mode == 0) begin
        if (log_v[i]) begin
          w = {w[23:0], log_d[i]};
          if (w == HEAD) begin
            mode = 1; w = '0; idle_n = 0;
          end
        end
      end else if (log_v[i]) begin
        idle_n = 0;
        if (mode == 1) begin
          if (int'(log_d[i]) < int'(N_CH)) begin
            if (i >= start) exp_s.push_back(mk(i, K_VS, 0, 1'b0, 1'b0, int'(log_d[i])));
            m_ch = int'(log_d[i]);
            mode = 2; pb.delete(); nbytes = 0; npix = 0;
          end else begin
            if (i >= start) exp_s.push_back(mk(i, K_ERR, 0, 1'b0, 1'b0, 1));
            m_err = 1;
            mode  = 0;
          end
        end else begin
          pb.push_back(log_d[i]);
          nbytes++;
          if (pb.size() == PIX_BYTES) begin
            val = 0;
            foreach (pb[k]) val = (val << 8) | int'(pb[k]);
            npix++;
            eol = (npix % LINE_PIX) == 0;
            eof = (nbytes == int'(FRAME_BYTES));
            if (i >= start) exp_s.push_back(mk(i, K_DE, val, eol, eof, 0));
            pb.delete();
            if (eof) begin
              m_frames = (m_frames + 1) % 65536;
              mode = 0;
            end
          end
        end
      end else begin
        idle_n++;
        if (idle_n == int'(TIMEOUT_CYC)) begin
          if (i >= start) exp_s.push_back(mk(i, K_ERR, 0, 1'b0, 1'b0, 2));
          m_err = 2;
          mode  = 0;
        end
      end
    end
    foreach (obs[i]) if (int'(obs[i][79:48]) >= start) obs_s.push_back(obs[i]);
  endfunction

  function automatic int count_de();
    int n = 0;
    foreach (obs_s[i]) if (int'(obs_s[i][47:44]) == K_DE) n++;
    return n;
  endfunction

  task automatic clear_logs();
    log_v.delete();
    log_d.delete();
    obs.delete();
  endtask

  task automatic test_reset();
    bus.app_rx_data_valid = 1'b0;
    bus.app_rx_data       = 8'h00;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.vid_vs, bus.vid_de, bus.vid_eol, bus.vid_eof, bus.err_pulse} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {bus.vid_vs, bus.vid_de, bus.vid_eol, bus.vid_eof, bus.err_pulse});
    end
    checks++;
    if (bus.vid_data !== '0 || bus.vid_ch !== '0) begin
      errors++;
      $display("FAIL reset_data: got data=%h ch=%h, expected 0", bus.vid_data, bus.vid_ch);
    end
    checks++;
    if (bus.frame_cnt !== 16'd0 || bus.err_code !== 2'b00) begin
      errors++;
      $display("FAIL reset_cnt: got frame_cnt=%0d err_code=%b, expected 0/00",
               bus.frame_cnt, bus.err_code);
    end
    @(negedge clk);
    rstn = 1'b1;
    clear_logs();
  endtask

  task automatic test_basic_frame();
    int t0 = log_v.size();
    send_head(0);
    send(8'h00, 0);
    for (int k = 0; k < 16; k++) send(8'(k), 0);
    idle(3);
    build(t0);
    checks++;
    if (obs_s.size() !== exp_s.size()) begin
      errors++;
      $display("FAIL basic_events: count %0d, expected %0d", obs_s.size(), exp_s.size());
    end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      checks++;
      if (obs_s[i] !== exp_s[i]) begin
        errors++;
        $display("FAIL basic_ev%0d: got %h, expected %h", i, obs_s[i], exp_s[i]);
      end
    end
    checks++;
    if (bus.frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL basic_frame_cnt: got %0d, expected 1", bus.frame_cnt);
    end
  endtask

  task automatic test_split_header();
    int t0 = log_v.size();
    send(8'hF3, 2); send(8'hF3, 2); send(8'hED, 2);
    send_frame(8'h01, 3);
    idle(3);
    build(t0);
    checks++;
    if (obs_s.size() !== exp_s.size()) begin
      errors++;
      $display("FAIL split_events: count %0d, expected %0d", obs_s.size(), exp_s.size());
    end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      checks++;
      if (obs_s[i] !== exp_s[i]) begin
        errors++;
        $display("FAIL split_ev%0d: got %h, expected %h", i, obs_s[i], exp_s[i]);
      end
    end
    checks++;
    if (bus.frame_cnt !== 16'(m_frames)) begin
      errors++;
      $display("FAIL split_frame_cnt: got %0d, expected %0d", bus.frame_cnt, m_frames);
    end
  endtask

  task automatic test_bad_channel();
    int t0 = log_v.size();
    send_head(1);
    send(8'h05, 0);
    idle(2);
    checks++;
    if (bus.err_code !== 2'b01) begin
      errors++;
      $display("FAIL badch_code: got %b, expected 01", bus.err_code);
    end
    send_frame(8'h01, 1);
    idle(3);
    build(t0);
    checks++;
    if (obs_s.size() !== exp_s.size()) begin
      errors++;
      $display("FAIL badch_events: count %0d, expected %0d", obs_s.size(), exp_s.size());
    end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      checks++;
      if (obs_s[i] !== exp_s[i]) begin
        errors++;
        $display("FAIL badch_ev%0d: got %h, expected %h", i, obs_s[i], exp_s[i]);
      end
    end
    checks++;
    if (bus.vid_ch !== 1'b1) begin
      errors++;
      $display("FAIL badch_vid_ch: got %0d, expected 1", bus.vid_ch);
    end
  endtask

  task automatic test_timeout();
    int t0 = log_v.size();
    int frames0;
    build(t0);
    frames0 = m_frames;
    send_head(0);
    send(8'h00, 0);
    for (int k = 0; k < 5; k++) send(8'($urandom), 2);
    idle(TIMEOUT_CYC + 3);
    build(t0);
    checks++;
    if (obs_s.size() !== exp_s.size()) begin
      errors++;
      $display("FAIL timeout_events: count %0d, expected %0d", obs_s.size(), exp_s.size());
    end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      checks++;
      if (obs_s[i] !== exp_s[i]) begin
        errors++;
        $display("FAIL timeout_ev%0d: got %h, expected %h", i, obs_s[i], exp_s[i]);
      end
    end
    checks++;
    if (count_de() !== 2) begin
      errors++;
      $display("FAIL timeout_de_count: got %0d, expected 2", count_de());
    end
    checks++;
    if (bus.err_code !== 2'b10 || bus.frame_cnt !== 16'(frames0)) begin
      errors++;
      $display("FAIL timeout_state: got err_code=%b frame_cnt=%0d, expected 10/%0d",
               bus.err_code, bus.frame_cnt, frames0);
    end
  endtask

  task automatic test_gap_boundary();
    int t0 = log_v.size();
    send_head(0);
    send(8'h00, 0);
    idle(TIMEOUT_CYC - 1);
    for (int k = 0; k < int'(FRAME_BYTES); k++) begin
      if (k == 3) idle(TIMEOUT_CYC - 1);
      send(8'($urandom), 0);
    end
    send_head(0);
    send(8'h01, 0);
    send(8'hAA, 0);
    idle(TIMEOUT_CYC);
    idle(2);
    build(t0);
    checks++;
    if (obs_s.size() !== exp_s.size()) begin
      errors++;
      $display("FAIL gap_events: count %0d, expected %0d", obs_s.size(), exp_s.size());
    end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      checks++;
      if (obs_s[i] !== exp_s[i]) begin
        errors++;
        $display("FAIL gap_ev%0d: got %h, expected %h", i, obs_s[i], exp_s[i]);
      end
    end
    checks++;
    if (bus.frame_cnt !== 16'(m_frames) || bus.err_code !== 2'(m_err)) begin
      errors++;
      $display("FAIL gap_state: got frame_cnt=%0d err=%0d, expected %0d/%0d",
               bus.frame_cnt, bus.err_code, m_frames, m_err);
    end
  endtask

  task automatic test_payload_header();
    int t0 = log_v.size();
    logic [7:0] pl[16];
    foreach (pl[k]) pl[k] = 8'($urandom);
    pl[4] = 8'hF3; pl[5] = 8'hED; pl[6] = 8'h7A; pl[7] = 8'h93;
    send_head(0);
    send(8'h00, 0);
    foreach (pl[k]) send(pl[k], 1);
    idle(3);
    build(t0);
    checks++;
    if (obs_s.size() !== exp_s.size()) begin
      errors++;
      $display("FAIL payhdr_events: count %0d, expected %0d", obs_s.size(), exp_s.size());
    end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      checks++;
      if (obs_s[i] !== exp_s[i]) begin
        errors++;
        $display("FAIL payhdr_ev%0d: got %h, expected %h", i, obs_s[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0 = log_v.size();
    for (int f = 0; f < 8; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) send(8'($urandom), 1);
      send_frame(8'($urandom_range(0, 2)), (f % 2 == 0) ? 0 : 3);
    end
    idle(3);
    build(t0);
    checks++;
    if (obs_s.size() !== exp_s.size()) begin
      errors++;
      $display("FAIL b2b_events: count %0d, expected %0d", obs_s.size(), exp_s.size());
    end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      checks++;
      if (obs_s[i] !== exp_s[i]) begin
        errors++;
        $display("FAIL b2b_ev%0d: got %h, expected %h", i, obs_s[i], exp_s[i]);
      end
    end
    checks++;
    if (bus.frame_cnt !== 16'(m_frames) || int'(bus.vid_ch) !== m_ch) begin
      errors++;
      $display("FAIL b2b_state: got frame_cnt=%0d ch=%0d, expected %0d/%0d",
               bus.frame_cnt, bus.vid_ch, m_frames, m_ch);
    end
  endtask

  task automatic test_reset_mid_rec();
    int t0;
    send_head(0);
    send(8'h01, 0);
    for (int k = 0; k < 7; k++) send(8'($urandom), 0);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.vid_vs, bus.vid_de, bus.vid_eol, bus.vid_eof, bus.err_pulse} !== 5'b0
        || bus.vid_data !== '0 || bus.vid_ch !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got flags=%b data=%h ch=%h, expected 0",
               {bus.vid_vs, bus.vid_de, bus.vid_eol, bus.vid_eof, bus.err_pulse},
               bus.vid_data, bus.vid_ch);
    end
    checks++;
    if (bus.frame_cnt !== 16'd0 || bus.err_code !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_cnt: got frame_cnt=%0d err_code=%b, expected 0/00",
               bus.frame_cnt, bus.err_code);
    end
    bus.app_rx_data_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    clear_logs();
    t0 = 0;
    send_frame(8'h01, 2);
    idle(3);
    build(t0);
    checks++;
    if (obs_s.size() !== exp_s.size()) begin
      errors++;
      $display("FAIL rstmid_events: count %0d, expected %0d", obs_s.size(), exp_s.size());
    end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      checks++;
      if (obs_s[i] !== exp_s[i]) begin
        errors++;
        $display("FAIL rstmid_ev%0d: got %h, expected %h", i, obs_s[i], exp_s[i]);
      end
    end
    checks++;
    if (bus.frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rstmid_frame_cnt: got %0d, expected 1", bus.frame_cnt);
    end
  endtask

  task automatic test_idle_data();
    checks++;
    if (idle_data_bad !== 0) begin
      errors++;
      $display("FAIL idle_data: %0d cycles with vid_data nonzero while vid_de=0, expected 0",
               idle_data_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_split_header();
    test_bad_channel();
    test_timeout();
    test_gap_boundary();
    test_payload_header();
    test_back_to_back();
    test_reset_mid_rec();
    test_idle_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
